// File: rtl/instr_mem.sv
// Instruction memory for the lab CPU: a byte-wide program store that is filled
// through a streaming load port and then read back by the CPU fetch counter.
module instr_mem #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetchaddr,
    output logic [DATA_W-1:0] instruction,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   prog_len,
    output logic              cpu_hold,
    output logic              overflow
);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL_LEN  = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              overflow_q, overflow_d;
    logic              cpu_hold_q;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              wr_en;
    logic              fetch_hit;

    logic [DATA_W-1:0] mem [DEPTH];

    // prog_len doubles as the write pointer, so a load can never wrap past DEPTH.
    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (load_start) begin
                    state_d    = LOAD;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    wr_en      = 1'b1;
                    prog_len_d = prog_len_q + (ADDR_W+1)'(1);
                    if (load_last || (prog_len_q == LAST_ADDR)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d    = LOAD;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end else if (load_valid && (prog_len_q == FULL_LEN)) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Reads past the loaded program return zero even when stale bytes remain.
    always_comb begin
        fetch_hit = ({1'b0, fetchaddr} < prog_len_q);
        instr_d   = '0;
        if ((state_q == RUN) && fetch_hit) begin
            instr_d = mem[fetchaddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            overflow_q <= overflow_d;
            cpu_hold_q <= (state_d != RUN);
            instr_q    <= instr_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[prog_len_q[ADDR_W-1:0]] <= load_data;
        end
    end

    assign instruction = instr_q;
    assign load_ready  = (state_q == LOAD);
    assign prog_len    = prog_len_q;
    assign cpu_hold    = cpu_hold_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: fetches push expected bytes into a queue and
// a monitor pops and compares them when the registered instruction appears.
module tb_instr_mem;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] fetchaddr;
    logic [DATA_W-1:0] instruction;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   prog_len;
    logic              cpu_hold;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] expQueue [$];
    logic              fetchStrobe = 1'b0;
    logic              strobeD     = 1'b0;

    instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetchaddr  (fetchaddr),
        .instruction(instruction),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .prog_len   (prog_len),
        .cpu_hold   (cpu_hold),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Fetch data lands one cycle after the address, so the strobe is delayed to match.
    always @(posedge clk) strobeD <= fetchStrobe;

    always @(negedge clk) begin
        if (strobeD) begin
            checks++;
            if (expQueue.size() == 0) begin
                failures++;
                $display("[TB] FAIL fetch_unexpected: actual=%02h required=no pending fetch", instruction);
            end else begin
                logic [DATA_W-1:0] exp;
                exp = expQueue.pop_front();
                if (instruction !== exp) begin
                    failures++;
                    $display("[TB] FAIL fetch_data: actual=%02h required=%02h", instruction, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic issueFetch(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        fetchaddr   = addr;
        expQueue.push_back(exp);
        fetchStrobe = 1'b1;
        @(negedge clk);
        fetchStrobe = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        fetchaddr  = '0;
        load_start = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;

        // Reset state, with load_start held high to show it is ignored under reset.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_instruction", 32'(instruction), 32'h00);
        checkOutput("rst_prog_len", 32'(prog_len), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        rst        = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        checkOutput("idle_load_ready", 32'(load_ready), 32'd0);

        // Basic three-byte program.
        startLoad();
        checkOutput("load1_ready", 32'(load_ready), 32'd1);
        checkOutput("load1_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b1);
        checkOutput("load1_prog_len", 32'(prog_len), 32'd3);
        checkOutput("load1_run_hold", 32'(cpu_hold), 32'd0);
        checkOutput("load1_run_ready", 32'(load_ready), 32'd0);
        issueFetch(11'd0, 8'h01);
        issueFetch(11'd1, 8'h02);
        issueFetch(11'd2, 8'h03);
        issueFetch(11'd3, 8'h00);

        // Valid toggling every other cycle: only the even cycles handshake.
        startLoad();
        for (int i = 0; i < 8; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = 8'h10 + 8'(i);
            load_last  = (i == 6);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkOutput("toggle_prog_len", 32'(prog_len), 32'd4);
        checkOutput("toggle_hold", 32'(cpu_hold), 32'd0);
        issueFetch(11'd0, 8'h10);
        issueFetch(11'd1, 8'h12);
        issueFetch(11'd2, 8'h14);
        issueFetch(11'd3, 8'h16);
        issueFetch(11'd4, 8'h00);

        // Reload from RUN: the read issued alongside load_start still completes.
        load_start  = 1'b1;
        fetchaddr   = 11'd1;
        expQueue.push_back(8'h12);
        fetchStrobe = 1'b1;
        @(negedge clk);
        load_start  = 1'b0;
        fetchaddr   = 11'd0;
        expQueue.push_back(8'h00);
        @(negedge clk);
        fetchStrobe = 1'b0;
        checkOutput("reload_hold", 32'(cpu_hold), 32'd1);
        checkOutput("reload_ready", 32'(load_ready), 32'd1);
        checkOutput("reload_prog_len_clear", 32'(prog_len), 32'd0);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("reload_prog_len", 32'(prog_len), 32'd1);
        checkOutput("reload_run_hold", 32'(cpu_hold), 32'd0);
        issueFetch(11'd0, 8'hAA);
        issueFetch(11'd1, 8'h00);

        // Reset in the middle of a load acts immediately.
        startLoad();
        for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i), 1'b0);
        checkOutput("midload_prog_len", 32'(prog_len), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_prog_len", 32'(prog_len), 32'd0);
        checkOutput("async_hold", 32'(cpu_hold), 32'd1);
        checkOutput("async_instruction", 32'(instruction), 32'h00);
        checkOutput("async_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_hold", 32'(cpu_hold), 32'd1);

        // Fill all 2048 locations without load_last, then push one byte too many.
        startLoad();
        for (int i = 0; i < 2048; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i) ^ 8'h5A;
            @(negedge clk);
        end
        load_data = 8'hEE;
        checkOutput("full_prog_len", 32'(prog_len), 32'd2048);
        checkOutput("full_ready", 32'(load_ready), 32'd0);
        checkOutput("full_hold", 32'(cpu_hold), 32'd0);
        checkOutput("full_overflow_pre", 32'(overflow), 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
        checkOutput("full_prog_len_hold", 32'(prog_len), 32'd2048);
        issueFetch(11'd0, 8'h5A);
        issueFetch(11'd1000, 8'hB2);
        issueFetch(11'd2047, 8'hA5);
        @(negedge clk);

        // Entering LOAD clears the sticky overflow.
        startLoad();
        checkOutput("overflow_cleared", 32'(overflow), 32'd0);

        for (int i = 0; i < 10 && expQueue.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQueue.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", expQueue.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
